// File: rtl/id_issue_stage_pkg.sv
// Shared decode definitions for the ID/issue stage: widths, opcode classes,
// instruction field positions and the decoded-instruction record.
package id_issue_stage_pkg;

  localparam int DSIZE = 16;
  localparam int ASIZE = 4;
  localparam int NREG  = 16;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef struct packed {
    logic [3:0]       op;
    logic [ASIZE-1:0] rd;
    logic [ASIZE-1:0] rs1;
    logic [ASIZE-1:0] rs2;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
    logic             illegal;
  } dec_t;

  // Illegal opcodes decode to a NOP so they flow through issue harmlessly.
  function automatic dec_t decode(input logic [15:0] instr);
    dec_t d;
    d.op        = instr[OP_MSB:OP_LSB];
    d.rd        = instr[RD_MSB:RD_LSB];
    d.rs1       = instr[RS1_MSB:RS1_LSB];
    d.rs2       = instr[RS2_MSB:RS2_LSB];
    d.uses_rs1  = 1'b0;
    d.uses_rs2  = 1'b0;
    d.writes_rd = 1'b0;
    d.illegal   = 1'b0;
    if (d.op >= OP_ALU_LO && d.op <= OP_ALU_HI) begin
      d.uses_rs1  = 1'b1;
      d.uses_rs2  = 1'b1;
      d.writes_rd = 1'b1;
    end else if (d.op == OP_LOAD) begin
      d.uses_rs1  = 1'b1;
      d.writes_rd = 1'b1;
    end else if (d.op == OP_STORE) begin
      d.uses_rs1 = 1'b1;
      d.uses_rs2 = 1'b1;
    end else if (d.op != OP_NOP) begin
      d.illegal = 1'b1;
      d.op      = OP_NOP;
    end
    return d;
  endfunction

endpackage

// File: rtl/id_issue_stage_scoreboard.sv
// Per-register pending-write scoreboard; hazard output is combinational and
// treats a same-cycle writeback to a register as already resolved.
module id_scoreboard
  import id_issue_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [ASIZE-1:0] set_addr_i,
  input  logic             clr_en_i,
  input  logic [ASIZE-1:0] clr_addr_i,
  input  logic [ASIZE-1:0] rs1_i,
  input  logic [ASIZE-1:0] rs2_i,
  input  logic [ASIZE-1:0] rd_i,
  input  logic             uses_rs1_i,
  input  logic             uses_rs2_i,
  input  logic             writes_rd_i,
  output logic             haz_o
);

  logic [NREG-1:0] pend_q, pend_d;

  // Set is applied after clear so a new writer wins over a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  logic clr_rs1, clr_rs2, clr_rd;
  assign clr_rs1 = clr_en_i && (clr_addr_i == rs1_i);
  assign clr_rs2 = clr_en_i && (clr_addr_i == rs2_i);
  assign clr_rd  = clr_en_i && (clr_addr_i == rd_i);

  assign haz_o = (uses_rs1_i  && pend_q[rs1_i] && !clr_rs1) ||
                 (uses_rs2_i  && pend_q[rs2_i] && !clr_rs2) ||
                 (writes_rd_i && pend_q[rd_i]  && !clr_rd);

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: one-entry IR, regfile read addressing, scoreboard hazard
// stall and registered EX slot. ID_STALL_CNT_EN builds the hazard stall counter.
module id_issue_stage
  import id_issue_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic [ASIZE-1:0] raddr1,
  output logic [ASIZE-1:0] raddr2,
  input  logic [DSIZE-1:0] rdata1,
  input  logic [DSIZE-1:0] rdata2,
  input  logic             wb_wen,
  input  logic [ASIZE-1:0] wb_waddr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [ASIZE-1:0] out_rd,
  output logic [DSIZE-1:0] out_a,
  output logic [DSIZE-1:0] out_b,
  output logic             illegal,
  output logic [15:0]      stall_cnt
);

  logic             ir_valid_q;
  logic [15:0]      ir_q;
  logic             out_valid_q, illegal_q;
  logic [3:0]       out_op_q;
  logic [ASIZE-1:0] out_rd_q;
  logic [DSIZE-1:0] out_a_q, out_b_q;
  dec_t             dec;
  logic             haz, issue;

  assign dec = decode(ir_q);

  // A flushed instruction is dropped, so it must not issue in the flush cycle.
  assign issue    = ir_valid_q && !flush && !haz && (!out_valid_q || out_ready);
  assign in_ready = !ir_valid_q || issue || flush;

  assign raddr1 = ir_valid_q ? dec.rs1 : '0;
  assign raddr2 = ir_valid_q ? dec.rs2 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_valid_q <= 1'b0;
      ir_q       <= '0;
    end else if (in_valid && in_ready) begin
      ir_valid_q <= 1'b1;
      ir_q       <= in_instr;
    end else if (issue || flush) begin
      ir_valid_q <= 1'b0;
    end
  end

  id_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (issue && dec.writes_rd),
    .set_addr_i  (dec.rd),
    .clr_en_i    (wb_wen),
    .clr_addr_i  (wb_waddr),
    .rs1_i       (dec.rs1),
    .rs2_i       (dec.rs2),
    .rd_i        (dec.rd),
    .uses_rs1_i  (dec.uses_rs1),
    .uses_rs2_i  (dec.uses_rs2),
    .writes_rd_i (dec.writes_rd),
    .haz_o       (haz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (issue) begin
        out_valid_q <= 1'b1;
        out_op_q    <= dec.op;
        out_rd_q    <= dec.rd;
        out_a_q     <= rdata1;
        out_b_q     <= dec.uses_rs2 ? rdata2 : '0;
        if (dec.illegal) illegal_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign illegal   = illegal_q;

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                                             stall_cnt_q <= '0;
    else if (ir_valid_q && haz && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
